// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file's single write port between the ALU (A)
//          and load (B) writeback paths, and tracks in-flight writes for decode.
// Latency: request accepted at edge N appears on write_* after edge N; the
//          register file commits it at edge N+1. One grant per cycle; B is
//          favoured, but A wins once it has been refused MAX_WAIT times in a row.
// Ports:   clk/reset; a_* and b_* valid/ready writeback requesters;
//          reserve_* decode claims; query_a1/a2 -> busy1/busy2 hazard lookup;
//          write_enable/write_index3/write_data3 to register_file; starve_count.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [4:0]       a_index,
  input  logic [31:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_index,
  input  logic [31:0]      b_data,
  output logic             b_ready,
  input  logic             reserve_valid,
  input  logic [4:0]       reserve_index,
  input  logic [4:0]       query_a1,
  input  logic [4:0]       query_a2,
  output logic             busy1,
  output logic             busy2,
  output logic             write_enable,
  output logic [4:0]       write_index3,
  output logic [31:0]      write_data3,
  output logic [CNT_W-1:0] starve_count
);

  logic        grant_a;
  logic        grant_b;
  logic        starved;
  logic        xfer;
  logic [4:0]  sel_index;
  logic [31:0] sel_data;
  logic [31:0] pending;
  logic [31:0] pending_nxt;

  // A may only beat a simultaneous B request once it has waited long enough.
  assign starved = (starve_count >= CNT_W'(MAX_WAIT));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = a_valid && (!b_valid || starved);
      grant_b = b_valid && !grant_a;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Ready already implies valid, so any grant is a transfer.
  assign xfer      = grant_a || grant_b;
  assign sel_index = grant_a ? a_index : b_index;
  assign sel_data  = grant_a ? a_data  : b_data;

  // Starvation counter: counts consecutive refused cycles of a valid A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_count <= '0;
    end else if (!a_valid || grant_a) begin
      starve_count <= '0;
    end else if (starve_count != {CNT_W{1'b1}}) begin
      starve_count <= starve_count + 1'b1;
    end
  end

  // Output register. Index-0 writes are accepted but dropped here by
  // leaving write_enable low; index/data still load so the port is coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_index3 <= '0;
      write_data3  <= '0;
    end else if (xfer) begin
      write_enable <= (sel_index != 5'd0);
      write_index3 <= sel_index;
      write_data3  <= sel_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Scoreboard update: the clear of the committing write is applied first so
  // that a reservation of the same register on the same edge survives; the
  // newer claim is still outstanding.
  always_comb begin
    pending_nxt = pending;
    if (write_enable) begin
      pending_nxt[write_index3] = 1'b0;
    end
    if (reserve_valid && (reserve_index != 5'd0)) begin
      pending_nxt[reserve_index] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign busy1 = pending[query_a1];
  assign busy2 = pending[query_a2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_index;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_index;
  logic [31:0] b_data;
  logic        b_ready;
  logic        reserve_valid;
  logic [4:0]  reserve_index;
  logic [4:0]  query_a1;
  logic [4:0]  query_a2;
  logic        busy1;
  logic        busy2;
  logic        write_enable;
  logic [4:0]  write_index3;
  logic [31:0] write_data3;
  logic [3:0]  starve_count;

  int checks;
  int errors;

  regfile_write_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .a_valid(a_valid),
    .a_index(a_index),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_index(b_index),
    .b_data(b_data),
    .b_ready(b_ready),
    .reserve_valid(reserve_valid),
    .reserve_index(reserve_index),
    .query_a1(query_a1),
    .query_a2(query_a2),
    .busy1(busy1),
    .busy2(busy2),
    .write_enable(write_enable),
    .write_index3(write_index3),
    .write_data3(write_data3),
    .starve_count(starve_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant pattern with both requesters valid and MAX_WAIT=4.
  logic [3:0] exp_starve [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic       exp_gnt_a  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    a_valid = 1'b0; a_index = '0; a_data = '0;
    b_valid = 1'b0; b_index = '0; b_data = '0;
    reserve_valid = 1'b0; reserve_index = '0;
    query_a1 = '0; query_a2 = '0;

    // Reset state; ready must stay low even with a request present.
    #3;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_we", write_enable, 0);
    check("rst_idx", write_index3, 0);
    check("rst_data", write_data3, 0);
    check("rst_starve", starve_count, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int q = 0; q < 32; q += 7) begin
      query_a1 = 5'(q);
      query_a2 = 5'(31 - q);
      #1;
      check("rst_busy1", busy1, 0);
      check("rst_busy2", busy2, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // A alone, index 5.
    a_valid = 1'b1; a_index = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("a_only_ready", a_ready, 1);
    check("a_only_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check("a_only_we", write_enable, 1);
    check("a_only_idx", write_index3, 5);
    check("a_only_data", write_data3, 32'hDEADBEEF);
    tick();
    check("a_only_we_drop", write_enable, 0);
    check("a_only_idx_hold", write_index3, 5);
    check("a_only_data_hold", write_data3, 32'hDEADBEEF);

    // Both valid continuously: B,B,B,B,A repeating.
    a_valid = 1'b1; a_index = 5'd3; a_data = 32'h0000_00A3;
    b_valid = 1'b1; b_index = 5'd4; b_data = 32'h0000_00B4;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("starve_count", starve_count, exp_starve[i]);
      check("arb_a_ready", a_ready, exp_gnt_a[i]);
      check("arb_b_ready", b_ready, !exp_gnt_a[i]);
      tick();
      check("arb_idx", write_index3, exp_gnt_a[i] ? 32'd3 : 32'd4);
      check("arb_data", write_data3, exp_gnt_a[i] ? 32'hA3 : 32'hB4);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("starve_clear_idle", starve_count, 0);

    // Reserve 7, then B writes 7: busy until the commit edge.
    reserve_valid = 1'b1; reserve_index = 5'd7;
    tick();
    reserve_valid = 1'b0;
    query_a1 = 5'd7;
    #1;
    check("res7_busy", busy1, 1);
    b_valid = 1'b1; b_index = 5'd7; b_data = 32'h12;
    #1;
    check("res7_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("res7_we", write_enable, 1);
    check("res7_busy_inflight", busy1, 1);
    tick();
    check("res7_busy_cleared", busy1, 0);
    check("res7_we_drop", write_enable, 0);

    // Reservation of 9 on the edge a write to 9 commits: set wins.
    reserve_valid = 1'b1; reserve_index = 5'd9;
    tick();
    reserve_valid = 1'b0;
    b_valid = 1'b1; b_index = 5'd9; b_data = 32'h99;
    tick();
    b_valid = 1'b0;
    check("res9_we", write_enable, 1);
    reserve_valid = 1'b1; reserve_index = 5'd9;
    tick();
    reserve_valid = 1'b0;
    query_a1 = 5'd9; query_a2 = 5'd9;
    #1;
    check("res9_busy1_kept", busy1, 1);
    check("res9_busy2_kept", busy2, 1);

    // Index-0 write is accepted and dropped; reserving 0 never marks busy.
    b_valid = 1'b1; b_index = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    check("idx0_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("idx0_we", write_enable, 0);
    reserve_valid = 1'b1; reserve_index = 5'd0;
    tick();
    reserve_valid = 1'b0;
    query_a1 = 5'd0;
    #1;
    check("idx0_busy", busy1, 0);

    // Reset while a write to 2 sits in the output register.
    a_valid = 1'b1; a_index = 5'd2; a_data = 32'h2222;
    tick();
    a_valid = 1'b0;
    check("mid_we_before", write_enable, 1);
    check("mid_idx_before", write_index3, 2);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_idx", write_index3, 0);
    check("mid_rst_data", write_data3, 0);
    check("mid_rst_busy9", busy2, 0);
    check("mid_rst_starve", starve_count, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (write_enable / write_index3 / write_data3) between two writeback sources: A = execute/ALU result, B = load/memory result.
- Arbitrates with valid/ready handshakes, registers the winning write, and keeps a 32-entry pending-write scoreboard.
- The decode stage queries the scoreboard and stalls on RAW hazards against writes still in flight.
- Sits between the execute/memory units and register_file.

Parameters:
- MAX_WAIT, 4: consecutive cycles A may be refused while valid before it is forced to win; range 1..15.
- CNT_W, 4: width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_index  in  5  A destination register.
- a_data  in  32  A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  requester B has a write.
- b_index  in  5  B destination register.
- b_data  in  32  B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- reserve_valid  in  1  decode claims a future write.
- reserve_index  in  5  register being claimed.
- query_a1  in  5  decode source register 1.
- query_a2  in  5  decode source register 2.
- busy1  out  1  query_a1 has a pending write (combinational).
- busy2  out  1  query_a2 has a pending write (combinational).
- write_enable  out  1  to register_file (registered).
- write_index3  out  5  to register_file (registered).
- write_data3  out  32  to register_file (registered).
- starve_count  out  CNT_W  current A refusal count, for debug.

Behaviour:
- Reset (asynchronous, immediate):
  - write_enable=0, write_index3=0, write_data3=0, starve_count=0.
  - Scoreboard cleared to all zeros.
  - a_ready and b_ready forced to 0 while reset is high.
- Arbitration (combinational, one grant per cycle):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: B wins, unless starve_count >= MAX_WAIT, in which case A wins.
  - Neither valid: no grant.
- Starvation counter:
  - Increments (saturating at its maximum) on each cycle A is valid and not granted.
  - Clears to 0 on any A grant, and on any cycle A is not valid.
- Handshake: a transfer occurs on the rising edge when valid && ready. Requesters must hold index/data stable while valid && !ready.
- Output register:
  - On a transfer, write_enable, write_index3 and write_data3 load the granted request on that edge. write_enable = 1 unless the index is 0.
  - Index-0 writes are accepted, drop with write_enable=0, and are never scoreboarded.
  - No transfer: write_enable loads 0; index and data hold.
  - Latency: request accepted at edge N; register_file commits at edge N+1.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - reserve_valid with nonzero index sets that bit on the edge.
  - A committed write (write_enable=1) clears bit[write_index3] on the edge it commits (N+1).
  - Set and clear of the same bit on the same edge: set wins, because the newer reservation is still outstanding.
  - Writes to unreserved registers are legal; the clear is a no-op.
  - busy1 = bit[query_a1]; busy2 = bit[query_a2]. Index 0 always reads 0.
- Both requesters targeting the same index are serialized in grant order; the last committed write is the final value.
- Reset asserted mid-transfer: the output register clears, so the pending write is lost; the scoreboard clears.

Test Plan:
- Reset → write_enable=0, write_index3=0, write_data3=0, busy1=busy2=0 for all queries, starve_count=0.
- A only, index 5, data 0xDEADBEEF, one cycle → a_ready=1 that cycle; next cycle write_enable=1, write_index3=5, write_data3=0xDEADBEEF; following cycle write_enable=0.
- A and B both valid continuously (A index 3, B index 4), MAX_WAIT=4 → grants B,B,B,B,A,B,B,B,B,A…; starve_count reaches 4 and then resets to 0 after the A grant.
- Reserve index 7, then B writes index 7 data 0x12 → busy1 (query_a1=7) stays 1 through the output-register cycle and reads 0 the cycle after commit.
- Reserve index 9 on the same edge a write to 9 commits → busy for 9 remains 1.
- B writes index 0 data 0xFFFFFFFF → b_ready=1; next cycle write_enable=0. Reserve index 0 → busy stays 0.
- Assert reset while write_enable=1 for index 2 → outputs clear immediately, without waiting for a clock edge; scoreboard empty.
